// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 configuration controller: FSM state
// encoding and the codec's I2C address constants.
package wm8731_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_e;

  // WM8731 with CSB tied low answers on 7'h1A; the write address byte is 8'h34.
  localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;
  localparam logic [7:0] WM8731_WR_ADDR  = {WM8731_DEV_ADDR, 1'b0};

  // First byte of a write transaction: 7-bit address followed by R/W=0.
  function automatic logic [7:0] wr_addr_byte(input logic [6:0] dev_addr);
    return {dev_addr, 1'b0};
  endfunction

endpackage

// File: rtl/wm8731_cfg_ctrl_if.sv
// Open-drain I2C bus as seen by a single master: SCL level, SDA pull-down
// enable and the sampled SDA line.
interface wm8731_cfg_ctrl_if;

  logic scl;
  logic sda_oe;
  logic sda_in;

  modport master (
    output scl,
    output sda_oe,
    input  sda_in
  );

  modport slave (
    input  scl,
    input  sda_oe,
    output sda_in
  );

endinterface

// File: rtl/i2c_tick_gen.sv
// Free-running divider producing a one-cycle quarter-bit tick every DIV clocks.
module i2c_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Count 0..DIV-1 and flag the wrap as the tick.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/wm8731_cfg_ctrl.sv
// WM8731 configuration controller: walks a register LUT and writes each
// 16-bit word to the codec over I2C, retrying NACKed words.
module wm8731_cfg_ctrl
  import wm8731_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned I2C_FREQ  = 100_000,
  parameter int unsigned LUT_SIZE  = 10,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [6:0]  DEV_ADDR  = WM8731_DEV_ADDR
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  output logic [7:0]  LUT_INDEX,
  input  logic [15:0] LUT_DATA,
  output logic        I2C_SCLK,
  output logic        I2C_SDAT_OE,
  input  logic        I2C_SDAT_IN,
  output logic        CFG_BUSY,
  output logic        CFG_DONE,
  output logic        CFG_ERR
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_q,     w_q_nxt;      // quarter within the current bit slot
  logic [2:0]  r_bit,   w_bit_nxt;    // bit within the current byte, MSB first
  logic [1:0]  r_byte,  w_byte_nxt;   // byte within the transaction
  logic [7:0]  r_index, w_index_nxt;
  logic [7:0]  r_retry, w_retry_nxt;
  logic [15:0] r_word,  w_word_nxt;
  logic        r_nack,  w_nack_nxt;
  logic        r_fetch, w_fetch_nxt;  // second FETCH cycle: LUT_DATA is valid
  logic        r_auto,  w_auto_nxt;   // pending auto-start after reset
  logic        r_scl,   w_scl;
  logic        r_oe,    w_oe;
  logic        w_tick;
  logic        w_slot_end;
  logic [7:0]  w_tx_byte;
  logic        w_tx_bit;

  i2c_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .i_clk  (iCLK),
    .i_rst  (iRST),
    .o_tick (w_tick)
  );

  assign w_slot_end = w_tick && (r_q == 2'd3);

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_q_nxt     = w_tick ? r_q + 2'd1 : r_q;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_index_nxt = r_index;
    w_retry_nxt = r_retry;
    w_word_nxt  = r_word;
    w_nack_nxt  = r_nack;
    w_fetch_nxt = r_fetch;
    w_auto_nxt  = r_auto;

    case (r_state)
      ST_IDLE: begin
        if (r_auto || iSTART) begin
          w_state_nxt = ST_FETCH;
          w_index_nxt = '0;
          w_retry_nxt = '0;
          w_fetch_nxt = 1'b0;
          w_auto_nxt  = 1'b0;
        end
      end
      ST_FETCH: begin
        if (r_fetch) begin
          w_word_nxt  = LUT_DATA;
          w_fetch_nxt = 1'b0;
          w_q_nxt     = 2'd0;
          w_state_nxt = ST_START;
        end else begin
          w_fetch_nxt = 1'b1;
        end
      end
      ST_START: begin
        if (w_slot_end) begin
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
          w_nack_nxt  = 1'b0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_slot_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      ST_ACK: begin
        if (w_tick && (r_q == 2'd2)) begin
          w_nack_nxt = I2C_SDAT_IN;
        end
        if (w_slot_end) begin
          if (r_nack || (r_byte == 2'd2)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_byte_nxt  = r_byte + 2'd1;
            w_bit_nxt   = '0;
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_STOP: begin
        if (w_slot_end) begin
          if (!r_nack) begin
            w_state_nxt = ST_GAP;
          end else if (r_retry >= 8'(MAX_RETRY)) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_retry_nxt = r_retry + 8'd1;
            w_state_nxt = ST_START;
          end
        end
      end
      ST_GAP: begin
        if (w_slot_end) begin
          if (r_index < 8'(LUT_SIZE - 1)) begin
            w_index_nxt = r_index + 8'd1;
            w_retry_nxt = '0;
            w_fetch_nxt = 1'b0;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (iSTART) begin
          w_index_nxt = '0;
          w_retry_nxt = '0;
          w_fetch_nxt = 1'b0;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (r_byte)
      2'd0:    w_tx_byte = wr_addr_byte(DEV_ADDR);
      2'd1:    w_tx_byte = r_word[15:8];
      default: w_tx_byte = r_word[7:0];
    endcase
  end

  assign w_tx_bit = w_tx_byte[3'd7 - r_bit];

  // Bus levels per slot quarter: SCL low in q0/q1, high in q2/q3.
  always_comb begin
    w_scl = 1'b1;
    w_oe  = 1'b0;
    case (r_state)
      ST_START: w_oe = r_q[1];                     // SDA falls while SCL high
      ST_SHIFT: begin
        w_scl = r_q[1];
        w_oe  = ~w_tx_bit;
      end
      ST_ACK:   w_scl = r_q[1];                    // SDA released for slave
      ST_STOP: begin
        w_scl = r_q[1];
        w_oe  = (r_q != 2'd3);                     // SDA rises while SCL high
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any transfer on the spot.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_index <= '0;
      r_retry <= '0;
      r_word  <= '0;
      r_nack  <= 1'b0;
      r_fetch <= 1'b0;
      r_auto  <= 1'b1;
      r_scl   <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_index <= w_index_nxt;
      r_retry <= w_retry_nxt;
      r_word  <= w_word_nxt;
      r_nack  <= w_nack_nxt;
      r_fetch <= w_fetch_nxt;
      r_auto  <= w_auto_nxt;
      r_scl   <= w_scl;
      r_oe    <= w_oe;
    end
  end

  assign LUT_INDEX   = r_index;
  assign I2C_SCLK    = r_scl;
  assign I2C_SDAT_OE = r_oe;
  assign CFG_DONE    = (r_state == ST_DONE);
  assign CFG_ERR     = (r_state == ST_ERROR);
  assign CFG_BUSY    = !((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                         (r_state == ST_ERROR));

endmodule

// File: tb/tb_wm8731_cfg_ctrl.sv
// Bench for wm8731_cfg_ctrl: registered LUT, I2C slave/monitor, directed scenarios.
module tb_wm8731_cfg_ctrl;

  localparam logic [15:0] EXP_W [10] = '{16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                         16'h0810, 16'h0A06, 16'h0C00, 16'h0E01,
                                         16'h1002, 16'h1201};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  lut_index;
  logic [15:0] lut_data = '0;
  logic        busy, done, err;
  logic        ack_drive = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  wm8731_cfg_ctrl_if bus ();
  assign bus.sda_in = ~(bus.sda_oe | ack_drive);

  wm8731_cfg_ctrl #(
    .CLK_FREQ  (4_000_000),
    .I2C_FREQ  (100_000),
    .LUT_SIZE  (10),
    .MAX_RETRY (3),
    .DEV_ADDR  (7'h1A)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iSTART      (start),
    .LUT_INDEX   (lut_index),
    .LUT_DATA    (lut_data),
    .I2C_SCLK    (bus.scl),
    .I2C_SDAT_OE (bus.sda_oe),
    .I2C_SDAT_IN (bus.sda_in),
    .CFG_BUSY    (busy),
    .CFG_DONE    (done),
    .CFG_ERR     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Configuration ROM with one cycle of read latency.
  always @(posedge clk) lut_data <= (lut_index < 8'd10) ? EXP_W[lut_index[3:0]] : 16'h0000;

  // Slave and bus monitor state.
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  logic        in_txn = 1'b0, have_rise = 1'b0, nacked = 1'b0, nack_once_done = 1'b0;
  int          bitcnt = 0, nbytes = 0, t_rise = 0, nack_mode = 0;
  int          bad_period = 0, bad_high = 0, viol = 0, nper = 0;
  logic [7:0]  sh = '0;
  logic [7:0]  rx [3];
  logic [24:0] txns [$];

  function automatic logic [24:0] exp_txn(input logic [15:0] w, input logic nk);
    return {nk, 8'h34, w};
  endfunction

  // Decode START/STOP/bits on the falling clock edge, drive ACK, time SCL.
  always @(negedge clk) begin : mon
    logic scl_v, sda_v;
    scl_v = bus.scl;
    sda_v = bus.sda_in;
    if (rst) begin
      in_txn    = 1'b0;
      ack_drive = 1'b0;
    end else if (prev_scl && scl_v && prev_sda && !sda_v) begin
      if (in_txn) viol++;
      in_txn = 1'b1; bitcnt = 0; nbytes = 0; nacked = 1'b0; have_rise = 1'b0;
    end else if (prev_scl && scl_v && !prev_sda && sda_v && in_txn) begin
      in_txn = 1'b0;
      if (nbytes != 3) viol++;
      txns.push_back({nacked, rx[0], rx[1], rx[2]});
    end else if (in_txn && !prev_scl && scl_v) begin
      if (have_rise) begin
        nper++;
        if ((cyc - t_rise) != 40) bad_period++;
      end
      have_rise = 1'b1;
      t_rise = cyc;
      if (bitcnt < 8) begin
        sh = {sh[6:0], sda_v};
        bitcnt++;
        if (bitcnt == 8 && nbytes < 3) begin
          rx[nbytes] = sh;
          nbytes++;
        end
      end else begin
        bitcnt = 0;
      end
    end else if (in_txn && prev_scl && !scl_v) begin
      if (have_rise && (cyc - t_rise) != 20) bad_high++;
      if (bitcnt == 8) begin
        ack_drive = 1'b1;
        if (nbytes == 3 && nack_mode == 1 && rx[1] == 8'h08 && !nack_once_done) begin
          ack_drive = 1'b0; nack_once_done = 1'b1; nacked = 1'b1;
        end
        if (nbytes == 3 && nack_mode == 2 && rx[1] == 8'h04) begin
          ack_drive = 1'b0; nacked = 1'b1;
        end
      end else begin
        ack_drive = 1'b0;
      end
    end
    prev_scl = scl_v;
    prev_sda = sda_v;
  end

  task automatic clear_mon();
    txns.delete();
    bad_period = 0; bad_high = 0; viol = 0; nper = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || err) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin
      $display("FAIL %s timeout: observed no DONE/ERR within %0d cycles, expected completion", name, budget);
      n_bad++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.scl !== 1'b1)    begin $display("FAIL reset scl: observed %b, expected 1", bus.scl); n_bad++; end
    n_cmp++; if (bus.sda_oe !== 1'b0) begin $display("FAIL reset oe: observed %b, expected 0", bus.sda_oe); n_bad++; end
    n_cmp++; if (lut_index !== 8'd0)  begin $display("FAIL reset index: observed %0d, expected 0", lut_index); n_bad++; end
    n_cmp++; if ({busy, done, err} !== 3'b000) begin $display("FAIL reset status: observed %b, expected 000", {busy, done, err}); n_bad++; end
  endtask

  task automatic test_full_pass();
    logic [24:0] got;
    clear_mon();
    @(negedge clk) rst = 1'b0;
    wait_end("full_pass", 20000);
    n_cmp++; if ({busy, done, err} !== 3'b010) begin $display("FAIL full_pass status: observed %b, expected 010", {busy, done, err}); n_bad++; end
    n_cmp++; if (txns.size() != 10) begin $display("FAIL full_pass count: observed %0d, expected 10", txns.size()); n_bad++; end
    for (int i = 0; i < 10; i++) begin
      got = (i < txns.size()) ? txns[i] : 25'h1FFFFFF;
      n_cmp++;
      if (got !== exp_txn(EXP_W[i], 1'b0)) begin
        $display("FAIL full_pass txn%0d: observed %h, expected %h", i, got, exp_txn(EXP_W[i], 1'b0)); n_bad++;
      end
    end
    got = (txns.size() > 0) ? txns[0] : 25'h1FFFFFF;
    n_cmp++; if (got !== 25'h0340017) begin $display("FAIL first_bytes: observed %h, expected 0340017", got); n_bad++; end
    got = (txns.size() > 9) ? txns[9] : 25'h1FFFFFF;
    n_cmp++; if (got !== 25'h0341201) begin $display("FAIL last_bytes: observed %h, expected 0341201", got); n_bad++; end
    n_cmp++; if (nper != 270)   begin $display("FAIL scl_periods: observed %0d, expected 270", nper); n_bad++; end
    n_cmp++; if (bad_period != 0) begin $display("FAIL scl_period_40: observed %0d bad, expected 0", bad_period); n_bad++; end
    n_cmp++; if (bad_high != 0) begin $display("FAIL scl_high_20: observed %0d bad, expected 0", bad_high); n_bad++; end
    n_cmp++; if (viol != 0)     begin $display("FAIL sda_protocol: observed %0d violations, expected 0", viol); n_bad++; end
    n_cmp++; if (lut_index !== 8'd9) begin $display("FAIL full_pass index: observed %0d, expected 9", lut_index); n_bad++; end
    n_cmp++; if ({bus.scl, bus.sda_oe} !== 2'b10) begin $display("FAIL full_pass bus idle: observed %b, expected 10", {bus.scl, bus.sda_oe}); n_bad++; end
  endtask

  task automatic test_back_to_back();
    logic [24:0] got;
    clear_mon();
    pulse_start();
    repeat (100) @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b10) begin $display("FAIL b2b busy: observed %b, expected 10", {busy, done}); n_bad++; end
    for (int i = 0; i < 20000 && txns.size() < 3; i++) @(negedge clk);
    pulse_start();
    wait_end("b2b", 20000);
    n_cmp++; if (txns.size() != 10) begin $display("FAIL b2b count: observed %0d, expected 10", txns.size()); n_bad++; end
    for (int i = 0; i < 10; i++) begin
      got = (i < txns.size()) ? txns[i] : 25'h1FFFFFF;
      n_cmp++;
      if (got !== exp_txn(EXP_W[i], 1'b0)) begin
        $display("FAIL b2b txn%0d: observed %h, expected %h", i, got, exp_txn(EXP_W[i], 1'b0)); n_bad++;
      end
    end
    n_cmp++; if ({busy, done, err} !== 3'b010) begin $display("FAIL b2b status: observed %b, expected 010", {busy, done, err}); n_bad++; end
  endtask

  task automatic test_nack_retry();
    logic [24:0] got, exp;
    clear_mon();
    nack_mode = 1; nack_once_done = 1'b0;
    pulse_start();
    wait_end("nack_retry", 20000);
    n_cmp++; if (txns.size() != 11) begin $display("FAIL nack_retry count: observed %0d, expected 11", txns.size()); n_bad++; end
    for (int i = 0; i < 11; i++) begin
      exp = exp_txn(EXP_W[(i <= 4) ? i : i - 1], (i == 4));
      got = (i < txns.size()) ? txns[i] : 25'h1FFFFFF;
      n_cmp++;
      if (got !== exp) begin $display("FAIL nack_retry txn%0d: observed %h, expected %h", i, got, exp); n_bad++; end
    end
    n_cmp++; if ({busy, done, err} !== 3'b010) begin $display("FAIL nack_retry status: observed %b, expected 010", {busy, done, err}); n_bad++; end
    nack_mode = 0;
  endtask

  task automatic test_perm_nack();
    logic [24:0] got, exp;
    clear_mon();
    nack_mode = 2;
    pulse_start();
    wait_end("perm_nack", 20000);
    n_cmp++; if (txns.size() != 6) begin $display("FAIL perm_nack count: observed %0d, expected 6", txns.size()); n_bad++; end
    for (int i = 0; i < 6; i++) begin
      exp = exp_txn(EXP_W[(i < 2) ? i : 2], (i >= 2));
      got = (i < txns.size()) ? txns[i] : 25'h1FFFFFF;
      n_cmp++;
      if (got !== exp) begin $display("FAIL perm_nack txn%0d: observed %h, expected %h", i, got, exp); n_bad++; end
    end
    repeat (200) @(negedge clk);
    n_cmp++; if ({busy, done, err} !== 3'b001) begin $display("FAIL perm_nack status: observed %b, expected 001", {busy, done, err}); n_bad++; end
    n_cmp++; if (lut_index !== 8'd2) begin $display("FAIL perm_nack index: observed %0d, expected 2", lut_index); n_bad++; end
    n_cmp++; if ({bus.scl, bus.sda_oe} !== 2'b10) begin $display("FAIL perm_nack bus: observed %b, expected 10", {bus.scl, bus.sda_oe}); n_bad++; end
    nack_mode = 0;
  endtask

  task automatic test_mid_reset();
    logic [24:0] got;
    logic hit;
    clear_mon();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (txns.size() == 5 && in_txn && nbytes == 1 && bitcnt == 3) begin hit = 1'b1; break; end
    end
    n_cmp++; if (!hit) begin $display("FAIL mid_reset trigger: observed none, expected word 5 mid-byte"); n_bad++; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({bus.scl, bus.sda_oe} !== 2'b10) begin $display("FAIL mid_reset bus: observed %b, expected 10", {bus.scl, bus.sda_oe}); n_bad++; end
    n_cmp++; if (lut_index !== 8'd0) begin $display("FAIL mid_reset index: observed %0d, expected 0", lut_index); n_bad++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL mid_reset busy: observed %b, expected 0", busy); n_bad++; end
    repeat (2) @(negedge clk);
    clear_mon();
    rst = 1'b0;
    wait_end("mid_reset", 20000);
    n_cmp++; if (txns.size() != 10) begin $display("FAIL mid_reset count: observed %0d, expected 10", txns.size()); n_bad++; end
    got = (txns.size() > 0) ? txns[0] : 25'h1FFFFFF;
    n_cmp++; if (got !== exp_txn(EXP_W[0], 1'b0)) begin $display("FAIL mid_reset first: observed %h, expected %h", got, exp_txn(EXP_W[0], 1'b0)); n_bad++; end
    got = (txns.size() > 5) ? txns[5] : 25'h1FFFFFF;
    n_cmp++; if (got !== exp_txn(EXP_W[5], 1'b0)) begin $display("FAIL mid_reset word5: observed %h, expected %h", got, exp_txn(EXP_W[5], 1'b0)); n_bad++; end
    n_cmp++; if (done !== 1'b1) begin $display("FAIL mid_reset done: observed %b, expected 1", done); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_back_to_back();
    test_nack_retry();
    test_perm_nack();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
